// File: rtl/inv_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inv_sequencer_pkg                                                    |
// | Shared state encoding, mux selects and helpers for the inversion FSM.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package inv_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SAVE     = 3'd2,
        ST_SQR      = 3'd3,
        ST_MUL_REQ  = 3'd4,
        ST_MUL_WAIT = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    // exp_sel = e asks the exponent unit for 2^e back-to-back squarings
    localparam logic [1:0] c_SQ1 = 2'd0;
    localparam logic [1:0] c_SQ2 = 2'd1;
    localparam logic [1:0] c_SQ4 = 2'd2;
    localparam logic [1:0] c_SQ8 = 2'd3;

    localparam logic c_OPB_S   = 1'b0;
    localparam logic c_OPB_A   = 1'b1;
    localparam logic c_RES_EXP = 1'b0;
    localparam logic c_RES_MUL = 1'b1;

    function automatic int msb_index(input int value);
        int idx;
        idx = 0;
        for (int b = 0; b < 31; b++) begin
            if (value[b]) idx = b;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_sq_chunker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inv_sq_chunker                                                       |
// | Largest squaring run 2^e (e <= 3) that fits in the remaining count.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module inv_sq_chunker
    import inv_sequencer_pkg::*;
#(
    parameter int KW = 5
) (
    input  logic [KW-1:0] i_rem,
    output logic [1:0]    o_exp_sel,
    output logic [KW-1:0] o_pow
);

    logic [31:0] w_rem;

    assign w_rem = 32'(i_rem);

    always_comb begin
        if (w_rem >= 32'd8)      o_exp_sel = c_SQ8;
        else if (w_rem >= 32'd4) o_exp_sel = c_SQ4;
        else if (w_rem >= 32'd2) o_exp_sel = c_SQ2;
        else                     o_exp_sel = c_SQ1;
    end

    assign o_pow = KW'(32'd1 << o_exp_sel);

endmodule
`default_nettype wire

// File: rtl/inv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inv_sequencer                                                        |
// | Itoh-Tsujii control for GF(2^M) inversion: squarings and multiplies. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module inv_sequencer
    import inv_sequencer_pkg::*;
#(
    parameter int M = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       ld_a,
    output logic       save,
    output logic       w_en,
    output logic       res_sel,
    output logic [1:0] exp_sel,
    output logic       opb_sel,
    output logic       mul_req,
    input  logic       mul_ack
);

    localparam int KW = $clog2(M) + 1;
    localparam int JW = $clog2(M);
    localparam int c_J0 = msb_index(M - 1) - 1;
    localparam logic [63:0] c_MM1 = 64'(M - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [KW-1:0] r_k;
    logic [KW-1:0] w_k_nxt;
    logic [KW-1:0] r_rem;
    logic [KW-1:0] w_rem_nxt;
    logic [KW-1:0] r_pow;
    logic [KW-1:0] w_rem_left;
    logic [JW-1:0] r_j;
    logic [JW-1:0] w_j_nxt;
    logic [JW-1:0] w_j_dec;
    logic [5:0]    w_jidx;
    logic          w_jbit;
    logic          r_inc;
    logic          w_inc_nxt;
    logic          r_fin;
    logic          w_fin_nxt;
    logic          w_mul_nxt;
    logic [1:0]    w_chunk_exp;
    logic [KW-1:0] w_chunk_pow;

    logic          r_busy;
    logic          r_done;
    logic          r_ld_a;
    logic          r_save;
    logic          r_w_en;
    logic          r_res_sel;
    logic [1:0]    r_exp_sel;
    logic          r_opb_sel;
    logic          r_mul_req;

    // j is read as two's complement; its top bit going high means all bits consumed
    assign w_j_dec    = r_j - JW'(1);
    assign w_jidx     = 6'(r_j);
    assign w_jbit     = c_MM1[w_jidx];
    assign w_rem_left = r_rem - r_pow;
    assign w_mul_nxt  = (w_state_nxt == ST_MUL_REQ) || (w_state_nxt == ST_MUL_WAIT);

    inv_sq_chunker #(
        .KW (KW)
    ) u_chunker (
        .i_rem     (w_rem_nxt),
        .o_exp_sel (w_chunk_exp),
        .o_pow     (w_chunk_pow)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_rem_nxt   = r_rem;
        w_j_nxt     = r_j;
        w_inc_nxt   = r_inc;
        w_fin_nxt   = r_fin;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_k_nxt   = KW'(1);
                w_j_nxt   = JW'(c_J0);
                w_inc_nxt = 1'b0;
                if (c_J0 < 0) begin
                    w_fin_nxt   = 1'b1;
                    w_rem_nxt   = KW'(1);
                    w_state_nxt = ST_SQR;
                end else begin
                    w_fin_nxt   = 1'b0;
                    w_state_nxt = ST_SAVE;
                end
            end
            ST_SAVE: begin
                w_rem_nxt   = r_k;
                w_state_nxt = ST_SQR;
            end
            ST_SQR: begin
                w_rem_nxt = w_rem_left;
                if (w_rem_left != '0) w_state_nxt = ST_SQR;
                else if (r_fin)       w_state_nxt = ST_DONE;
                else                  w_state_nxt = ST_MUL_REQ;
            end
            ST_MUL_REQ: begin
                w_state_nxt = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                if (mul_ack) begin
                    if (!r_inc && w_jbit) begin
                        w_k_nxt     = r_k << 1;
                        w_inc_nxt   = 1'b1;
                        w_rem_nxt   = KW'(1);
                        w_state_nxt = ST_SQR;
                    end else begin
                        w_k_nxt   = r_inc ? (r_k + KW'(1)) : (r_k << 1);
                        w_inc_nxt = 1'b0;
                        w_j_nxt   = w_j_dec;
                        if (w_j_dec[JW-1]) begin
                            w_fin_nxt   = 1'b1;
                            w_rem_nxt   = KW'(1);
                            w_state_nxt = ST_SQR;
                        end else begin
                            w_state_nxt = ST_SAVE;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave flops directly.
    // W follows the product bus for the whole wait; the value on the ack edge is the one kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_rem     <= '0;
            r_pow     <= '0;
            r_j       <= '0;
            r_inc     <= 1'b0;
            r_fin     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ld_a    <= 1'b0;
            r_save    <= 1'b0;
            r_w_en    <= 1'b0;
            r_res_sel <= c_RES_EXP;
            r_exp_sel <= c_SQ1;
            r_opb_sel <= c_OPB_S;
            r_mul_req <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_rem     <= w_rem_nxt;
            r_pow     <= w_chunk_pow;
            r_j       <= w_j_nxt;
            r_inc     <= w_inc_nxt;
            r_fin     <= w_fin_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
            r_done    <= (w_state_nxt == ST_DONE);
            r_ld_a    <= (w_state_nxt == ST_LOAD);
            r_save    <= (w_state_nxt == ST_SAVE);
            r_w_en    <= (w_state_nxt == ST_SQR) || (w_state_nxt == ST_MUL_WAIT);
            r_res_sel <= (w_state_nxt == ST_MUL_WAIT) ? c_RES_MUL : c_RES_EXP;
            r_exp_sel <= (w_state_nxt == ST_SQR) ? w_chunk_exp : c_SQ1;
            r_opb_sel <= (w_mul_nxt && w_inc_nxt) ? c_OPB_A : c_OPB_S;
            r_mul_req <= w_mul_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign ld_a    = r_ld_a;
    assign save    = r_save;
    assign w_en    = r_w_en;
    assign res_sel = r_res_sel;
    assign exp_sel = r_exp_sel;
    assign opb_sel = r_opb_sel;
    assign mul_req = r_mul_req;

endmodule
`default_nettype wire
